mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported 16-bit unified memory between the instruction-fetch stage (IF) and the memory stage (LS, driven by EX/MEM buffer outputs).
- Sequences one access at a time over a req/ack memory handshake.
- Returns read data to the owning requester.
- Drives stall signals that freeze the pipeline buffers until each requester's access completes.
- LS has priority; a starvation counter guarantees fetch forward progress.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MAX_WAIT, 4, consecutive LS grants tolerated while IF is pending before IF is forced (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
if_req  input  1  fetch request, held until if_done
if_addr  input  ADDR_W  fetch address
if_rdata  output  DATA_W  fetched word, registered, held until next IF completion
if_done  output  1  one-cycle IF completion pulse
if_stall  output  1  if_req & ~if_done (combinational)
ls_read  input  1  load request (EX/MEM memRead)
ls_write  input  1  store request (EX/MEM memWrite)
ls_addr  input  ADDR_W  load/store address (ALU result)
ls_wdata  input  DATA_W  store data
ls_rdata  output  DATA_W  loaded word, registered, held until next LS read completion
ls_done  output  1  one-cycle LS completion pulse
ls_stall  output  1  (ls_read|ls_write) & ~ls_done (combinational)
mem_req  output  1  memory request
mem_we  output  1  1 = write
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_ack  input  1  memory completion; read data valid in the same cycle
mem_rdata  input  DATA_W  memory read data
grant_ls  output  1  1 while LS owns the port (LS_ACC/LS_DONE)

Behaviour:
- Reset is asynchronous, active-low; clock is clk. On reset, all outputs are 0, the FSM goes to IDLE and starve_cnt is 0.
- FSM states: IDLE, IF_ACC, LS_ACC, IF_DONE, LS_DONE. All state-derived outputs are registered/Moore.
- IDLE:
  - ls_pend = ls_read|ls_write.
  - If ls_pend and if_req: go to IF_ACC when starve_cnt==MAX_WAIT, else LS_ACC.
  - If only one is pending, grant it. If none, stay in IDLE.
- Grant edge:
  - Capture addr, wdata and we into mem_addr/mem_wdata/mem_we.
  - we = ls_write for LS (a write wins if ls_read and ls_write are both set); we = 0 for IF.
  - Requester input changes after the grant are ignored until the next grant.
- IF_ACC/LS_ACC:
  - mem_req=1; mem_addr, mem_wdata and mem_we are stable.
  - On an edge with mem_ack=1: go to *_DONE. For a read, capture mem_rdata into if_rdata or ls_rdata; a write leaves ls_rdata unchanged.
  - Wait states are unbounded.
- *_DONE:
  - mem_req=0 and the corresponding done=1 for exactly one cycle.
  - Unconditionally go to IDLE; no grant is made in this state, so the requester can advance or drop its request.
- Latency: with zero-wait memory (ack in the first ACC cycle), a request seen in IDLE at cycle 0 gives done at cycle 2 and re-arbitration at cycle 3. Each memory wait cycle adds 1.
- starve_cnt:
  - Increments (saturating at MAX_WAIT) on each LS grant made while if_req=1.
  - Clears on an IF grant, or in any IDLE cycle with if_req=0.
- mem_ack outside the ACC states is ignored.
- mem_req, mem_we, mem_addr and mem_wdata are 0 in IDLE and DONE.
- Reset mid-access: mem_req drops immediately (async) and starve_cnt clears. A stale ack arriving after reset release is ignored. The requester must re-present the request, and it re-executes.
- Stalls are purely combinational. A requester seeing done=1 advances at that edge.

Test Plan:
1. IF only, if_addr=0x0010, mem_ack same cycle as mem_req, mem_rdata=0xBEEF -> mem_req/addr 0x0010/we=0 in cycle 1; if_done and if_rdata=0xBEEF in cycle 2; if_stall=1 in cycles 0-1 and 0 in cycle 2.
2. LS store, ls_addr=0x0200, ls_wdata=0x1234, ack after 3 wait cycles -> mem_req=1, we=1, addr/wdata stable for 4 cycles; ls_done one cycle after ack; ls_rdata unchanged; grant_ls=1 throughout.
3. MAX_WAIT=2, if_req and ls_read continuously high, zero-wait memory -> grant order LS, LS, IF, LS, LS, IF; each done pulses exactly once per access.
4. reset driven low during LS_ACC wait -> mem_req, grant_ls and ls_done are 0 immediately. After release, mem_ack=1 pulsed in IDLE with no request -> no done and no state change.
5. ls_read=ls_write=1, ls_addr=0x0042 -> single write access, mem_we=1.
6. ls_addr changed 0x0300->0x0304 mid-access -> mem_addr stays 0x0300 until done; the next access uses 0x0304.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle for the fetch port, the load/store port and the shared memory handshake.
// The arbiter sits on the slave modport; the master modport drives requests and models the memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_stall;

  logic              ls_read;
  logic              ls_write;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_done;
  logic              ls_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              grant_ls;

  modport slave (
    input  if_req, if_addr, ls_read, ls_write, ls_addr, ls_wdata, mem_ack, mem_rdata,
    output if_rdata, if_done, if_stall, ls_rdata, ls_done, ls_stall,
           mem_req, mem_we, mem_addr, mem_wdata, grant_ls
  );

  modport master (
    output if_req, if_addr, ls_read, ls_write, ls_addr, ls_wdata, mem_ack, mem_rdata,
    input  if_rdata, if_done, if_stall, ls_rdata, ls_done, ls_stall,
           mem_req, mem_we, mem_addr, mem_wdata, grant_ls
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (IF) and load/store (LS), one access at a time.
// LS has priority; after MAX_WAIT LS grants made while IF waits, IF is forced in next.
module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_IF_ACC  = 3'd1;
  localparam logic [2:0] ST_LS_ACC  = 3'd2;
  localparam logic [2:0] ST_IF_DONE = 3'd3;
  localparam logic [2:0] ST_LS_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              ls_pend;
  logic              in_acc;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    ls_pend    = bus.ls_read | bus.ls_write;

    case (state_q)
      ST_IDLE: begin
        if (bus.if_req && (!ls_pend || starve_q == CNT_MAX)) begin
          state_d  = ST_IF_ACC;
          addr_d   = bus.if_addr;
          wdata_d  = '0;
          we_d     = 1'b0;
          starve_d = '0;
        end else if (ls_pend) begin
          // A write wins when both read and write are asserted.
          state_d = ST_LS_ACC;
          addr_d  = bus.ls_addr;
          wdata_d = bus.ls_wdata;
          we_d    = bus.ls_write;
          // Reaching here with if_req set implies starve_q is still below the limit.
          if (bus.if_req) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end
        if (!bus.if_req) begin
          starve_d = '0;
        end
      end
      ST_IF_ACC: begin
        if (bus.mem_ack) begin
          state_d    = ST_IF_DONE;
          if_rdata_d = bus.mem_rdata;
        end
      end
      ST_LS_ACC: begin
        if (bus.mem_ack) begin
          state_d = ST_LS_DONE;
          if (!we_q) begin
            ls_rdata_d = bus.mem_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // Bus outputs are decoded from the state register only, so they drop with reset.
  assign in_acc        = (state_q == ST_IF_ACC) || (state_q == ST_LS_ACC);
  assign bus.mem_req   = in_acc;
  assign bus.mem_we    = in_acc & we_q;
  assign bus.mem_addr  = in_acc ? addr_q : '0;
  assign bus.mem_wdata = in_acc ? wdata_q : '0;
  assign bus.grant_ls  = (state_q == ST_LS_ACC) || (state_q == ST_LS_DONE);
  assign bus.if_done   = (state_q == ST_IF_DONE);
  assign bus.ls_done   = (state_q == ST_LS_DONE);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.if_stall  = bus.if_req & ~bus.if_done;
  assign bus.ls_stall  = (bus.ls_read | bus.ls_write) & ~bus.ls_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed multi-cycle sequences, then random traffic
// against a transaction-level model of the arbitration rules and a behavioural memory.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic        if_req;
    logic [15:0] if_addr;
    logic        ls_read;
    logic        ls_write;
    logic [15:0] ls_addr;
    logic [15:0] ls_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
  } ins_t;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        if_done;
    logic        ls_done;
    logic        if_stall;
    logic        ls_stall;
    logic        grant_ls;
    logic [15:0] if_rdata;
    logic [15:0] ls_rdata;
  } outs_t;

  typedef struct {
    ins_t  i;
    outs_t o;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[13];
  outs_t o;
  logic [15:0] mem_model [logic [15:0]];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ins_t mk_in(logic ifr, logic [15:0] ia, logic lr, logic lw, logic [15:0] la,
                                 logic [15:0] lwd, logic ack, logic [15:0] rd);
    ins_t v;
    v.if_req = ifr; v.if_addr = ia; v.ls_read = lr; v.ls_write = lw;
    v.ls_addr = la; v.ls_wdata = lwd; v.mem_ack = ack; v.mem_rdata = rd;
    return v;
  endfunction

  function automatic outs_t mk_out(logic req, logic we, logic [15:0] a, logic [15:0] wd, logic ifd,
                                   logic lsd, logic ifs, logic lss, logic gls, logic [15:0] ifrd,
                                   logic [15:0] lsrd);
    outs_t v;
    v.mem_req = req; v.mem_we = we; v.mem_addr = a; v.mem_wdata = wd; v.if_done = ifd;
    v.ls_done = lsd; v.if_stall = ifs; v.ls_stall = lss; v.grant_ls = gls;
    v.if_rdata = ifrd; v.ls_rdata = lsrd;
    return v;
  endfunction

  function automatic outs_t sample();
    outs_t v;
    v.mem_req = bus.mem_req; v.mem_we = bus.mem_we; v.mem_addr = bus.mem_addr;
    v.mem_wdata = bus.mem_wdata; v.if_done = bus.if_done; v.ls_done = bus.ls_done;
    v.if_stall = bus.if_stall; v.ls_stall = bus.ls_stall; v.grant_ls = bus.grant_ls;
    v.if_rdata = bus.if_rdata; v.ls_rdata = bus.ls_rdata;
    return v;
  endfunction

  function automatic logic [15:0] mem_read(logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 16'hA5A5;
  endfunction

  task automatic apply(input ins_t v);
    bus.if_req = v.if_req; bus.if_addr = v.if_addr; bus.ls_read = v.ls_read;
    bus.ls_write = v.ls_write; bus.ls_addr = v.ls_addr; bus.ls_wdata = v.ls_wdata;
    bus.mem_ack = v.mem_ack; bus.mem_rdata = v.mem_rdata;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit was_idle, idle_if, idle_ls, busy, acked, owner_ls, exp_owner;
    int ls_waited, wait_left, if_age, ls_age, max_if_age, max_ls_age, n_if, n_ls;
    logic [15:0] exp_if_rd, exp_ls_rd, a;
    logic q_grants[$];

    // IF fetch, write-wins LS access, stray ack in IDLE, ack ignored in IDLE then LS read
    tbl[0]  = '{mk_in(1, 16'h0010, 0, 0, 0, 0, 0, 0),              mk_out(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)};
    tbl[1]  = '{mk_in(1, 16'h0010, 0, 0, 0, 0, 1, 16'hBEEF),        mk_out(1, 0, 16'h0010, 0, 0, 0, 1, 0, 0, 0, 0)};
    tbl[2]  = '{mk_in(1, 16'h0010, 0, 0, 0, 0, 0, 0),              mk_out(0, 0, 0, 0, 1, 0, 0, 0, 0, 16'hBEEF, 0)};
    tbl[3]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0),                     mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hBEEF, 0)};
    tbl[4]  = '{mk_in(0, 0, 1, 1, 16'h0042, 16'h5A5A, 0, 0),       mk_out(0, 0, 0, 0, 0, 0, 0, 1, 0, 16'hBEEF, 0)};
    tbl[5]  = '{mk_in(0, 0, 1, 1, 16'h0042, 16'h5A5A, 1, 16'hDEAD), mk_out(1, 1, 16'h0042, 16'h5A5A, 0, 0, 0, 1, 1, 16'hBEEF, 0)};
    tbl[6]  = '{mk_in(0, 0, 1, 1, 16'h0042, 16'h5A5A, 0, 0),       mk_out(0, 0, 0, 0, 0, 1, 0, 0, 1, 16'hBEEF, 0)};
    tbl[7]  = '{mk_in(0, 0, 0, 0, 0, 0, 1, 16'h1111),              mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hBEEF, 0)};
    tbl[8]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0),                     mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hBEEF, 0)};
    tbl[9]  = '{mk_in(0, 0, 1, 0, 16'h0042, 0, 1, 16'hCAFE),       mk_out(0, 0, 0, 0, 0, 0, 0, 1, 0, 16'hBEEF, 0)};
    tbl[10] = '{mk_in(0, 0, 1, 0, 16'h0042, 0, 1, 16'hCAFE),       mk_out(1, 0, 16'h0042, 0, 0, 0, 0, 1, 1, 16'hBEEF, 0)};
    tbl[11] = '{mk_in(0, 0, 1, 0, 16'h0042, 0, 0, 0),              mk_out(0, 0, 0, 0, 0, 1, 0, 0, 1, 16'hBEEF, 16'hCAFE)};
    tbl[12] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0),                     mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hBEEF, 16'hCAFE)};

    reset = 1'b0;
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    check("reset_outputs", sample(), '0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      apply(tbl[i].i);
      #1;
      check($sformatf("vec%0d", i), sample(), tbl[i].o);
    end

    // LS store with three wait states
    @(negedge clk);
    apply(mk_in(0, 0, 0, 1, 16'h0200, 16'h1234, 0, 0));
    #1 check("store_idle", bus.mem_req, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.mem_ack = (k == 3); bus.mem_rdata = 16'hFFFF;
      #1 check($sformatf("store_acc%0d", k),
               {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.grant_ls, bus.ls_done},
               {1'b1, 1'b1, 16'h0200, 16'h1234, 1'b1, 1'b0});
    end
    @(negedge clk);
    bus.mem_ack = 0;
    #1 check("store_done", {bus.mem_req, bus.ls_done, bus.grant_ls, bus.ls_rdata},
             {1'b0, 1'b1, 1'b1, 16'hCAFE});
    @(negedge clk);
    bus.ls_write = 0;
    #1 check("store_after", {bus.ls_done, bus.grant_ls}, 2'b00);

    // Address change mid-access is ignored until the next grant
    @(negedge clk);
    apply(mk_in(0, 0, 1, 0, 16'h0300, 0, 0, 0));
    @(negedge clk);
    bus.ls_addr = 16'h0304;
    #1 check("chg_hold0", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0300});
    @(negedge clk);
    bus.mem_ack = 1; bus.mem_rdata = 16'h7777;
    #1 check("chg_hold1", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0300});
    @(negedge clk);
    bus.mem_ack = 0;
    #1 check("chg_done", {bus.ls_done, bus.ls_rdata}, {1'b1, 16'h7777});
    @(negedge clk);
    #1 check("chg_idle", bus.mem_req, 0);
    @(negedge clk);
    bus.mem_ack = 1; bus.mem_rdata = 16'h8888;
    #1 check("chg_next", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0304});
    @(negedge clk);
    bus.mem_ack = 0;
    #1 check("chg_next_done", {bus.ls_done, bus.ls_rdata}, {1'b1, 16'h8888});
    @(negedge clk);
    bus.ls_read = 0;

    // Starvation limit: both requesting continuously with zero-wait memory
    @(negedge clk);
    apply(mk_in(1, 16'h0100, 1, 0, 16'h0400, 0, 1, 16'h2222));
    n_if = 0; n_ls = 0;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.mem_req && bus.mem_addr != 16'h0) begin
        if (q_grants.size() == 0 || c % 3 == 1) q_grants.push_back(bus.grant_ls);
      end
      n_if += int'(bus.if_done);
      n_ls += int'(bus.ls_done);
    end
    check("starve_ngrants", q_grants.size(), 6);
    for (int g = 0; g < 6 && g < q_grants.size(); g++)
      check($sformatf("starve_grant%0d", g), q_grants[g], (g % 3 == 2) ? 1'b0 : 1'b1);
    check("starve_if_dones", n_if, 2);
    check("starve_ls_dones", n_ls, 4);
    @(negedge clk);
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0));

    // Reset during an LS wait state, then a stale ack with no request
    @(negedge clk);
    apply(mk_in(0, 0, 1, 0, 16'h0500, 0, 0, 0));
    @(negedge clk);
    #1 check("rst_pre", {bus.mem_req, bus.grant_ls}, 2'b11);
    #2 reset = 1'b0;
    #1 check("rst_async", {bus.mem_req, bus.grant_ls, bus.ls_done}, 3'b000);
    bus.ls_read = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1;
    #1 check("rst_stale0", {bus.mem_req, bus.ls_done, bus.if_done, bus.grant_ls}, 4'b0000);
    @(negedge clk);
    bus.mem_ack = 0;
    #1 check("rst_stale1", {bus.mem_req, bus.ls_done, bus.if_done, bus.grant_ls}, 4'b0000);
    @(negedge clk);
    bus.ls_read = 1; bus.ls_addr = 16'h0500;
    @(negedge clk);
    bus.mem_ack = 1; bus.mem_rdata = 16'h4444;
    #1 check("rst_reexec", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0500});
    @(negedge clk);
    bus.mem_ack = 0;
    #1 check("rst_reexec_done", {bus.ls_done, bus.ls_rdata, bus.if_rdata}, {1'b1, 16'h4444, 16'h0000});
    @(negedge clk);
    bus.ls_read = 0;
    @(negedge clk);
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0));

    // Random traffic against the transaction-level model
    exp_if_rd = 16'h0000; exp_ls_rd = 16'h4444;
    was_idle = 1; idle_if = 0; idle_ls = 0; busy = 0; acked = 0; owner_ls = 0;
    ls_waited = 0; wait_left = 0; if_age = 0; ls_age = 0; max_if_age = 0; max_ls_age = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      o = sample();
      check("rnd_if_done", o.if_done, acked && !owner_ls);
      check("rnd_ls_done", o.ls_done, acked && owner_ls);
      check("rnd_if_stall", o.if_stall, bus.if_req && !o.if_done);
      check("rnd_ls_stall", o.ls_stall, (bus.ls_read || bus.ls_write) && !o.ls_done);
      check("rnd_rdata", {o.if_rdata, o.ls_rdata}, {exp_if_rd, exp_ls_rd});
      if (was_idle) begin
        check("rnd_grant", o.mem_req, idle_if || idle_ls);
        if (o.mem_req) begin
          exp_owner = idle_ls && (!idle_if || ls_waited < MW);
          check("rnd_owner", o.grant_ls, exp_owner);
          if (!exp_owner) ls_waited = 0;
          else if (idle_if) ls_waited++;
          owner_ls = exp_owner;
          busy = 1;
          wait_left = $urandom_range(0, 3);
        end
      end else begin
        check("rnd_req_hold", o.mem_req, busy);
      end
      if (o.mem_req) begin
        a = owner_ls ? bus.ls_addr : bus.if_addr;
        check("rnd_bus", {o.mem_addr, o.mem_we}, {a, owner_ls && bus.ls_write});
        if (owner_ls && bus.ls_write) check("rnd_wdata", o.mem_wdata, bus.ls_wdata);
      end
      if (bus.if_req && !o.if_done) if_age++; else if_age = 0;
      if ((bus.ls_read || bus.ls_write) && !o.ls_done) ls_age++; else ls_age = 0;
      if (if_age > max_if_age) max_if_age = if_age;
      if (ls_age > max_ls_age) max_ls_age = ls_age;
      was_idle = !o.mem_req && !o.if_done && !o.ls_done;

      if (o.if_done) bus.if_req = 0;
      if (!bus.if_req && $urandom_range(0, 2) != 0) begin
        bus.if_req = 1; bus.if_addr = {12'h0, 4'($urandom)};
      end
      if (o.ls_done) begin bus.ls_read = 0; bus.ls_write = 0; end
      if (!(bus.ls_read || bus.ls_write) && $urandom_range(0, 2) != 0) begin
        n_ls = $urandom_range(1, 3);
        bus.ls_read = n_ls[0]; bus.ls_write = n_ls[1];
        bus.ls_addr = {12'h0, 4'($urandom)}; bus.ls_wdata = 16'($urandom);
      end
      idle_if = bus.if_req;
      idle_ls = bus.ls_read || bus.ls_write;

      acked = 0;
      bus.mem_rdata = 16'($urandom);
      if (busy) begin
        if (wait_left == 0) begin
          bus.mem_ack = 1;
          acked = 1;
          busy = 0;
          if (owner_ls && o.mem_we) mem_model[o.mem_addr] = o.mem_wdata;
          else begin
            bus.mem_rdata = mem_read(o.mem_addr);
            if (owner_ls) exp_ls_rd = bus.mem_rdata;
            else exp_if_rd = bus.mem_rdata;
          end
        end else begin
          wait_left--;
          bus.mem_ack = 0;
        end
      end else begin
        bus.mem_ack = ($urandom_range(0, 3) == 0);
      end
    end
    check("rnd_if_max_wait", max_if_age <= 40, 1'b1);
    check("rnd_ls_max_wait", max_ls_age <= 40, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
